// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl
//
// Sequencing controller for a WIDTH-bit down counter. It loads a start
// value, decrements it once every DIV clock cycles, can be paused or
// aborted, and flags terminal count with a one-cycle done pulse.
// Fully synchronous, single clock domain.
//
// Parameters
//   WIDTH     counter width in bits (>= 1)
//   DIV       clock cycles per decrement (>= 1)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   begin a countdown (only honoured in IDLE)
//   load_val  in   start value, captured when a start is accepted
//   pause     in   level; freezes prescaler and count while high in RUN
//   abort     in   cancel; back to IDLE with count cleared, no done
//   count     out  current count value (registered)
//   busy      out  high in RUN and DONE (registered)
//   done      out  one-cycle terminal-count pulse (registered)
//
// Build option
//   AUTO_RELOAD_EN  when defined, terminal count reloads the captured
//                   start value and the counter keeps running (periodic
//                   mode); it only stops on abort or reset.
module down_counter_ctrl #(
  parameter int WIDTH = 3,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic             armed_q, armed_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // The first RUN cycle after a load is an arming cycle with no prescaler
  // activity, so the first decrement lands DIV cycles after the value
  // becomes visible one cycle past the start edge. Pause freezes arming
  // too, so every paused cycle delays done by exactly one cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pre_d    = pre_q;
    armed_d  = armed_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      pre_d   = '0;
      armed_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (start) begin
            if (load_val != '0) begin
              count_d  = load_val;
`ifdef AUTO_RELOAD_EN
              reload_d = load_val;
`endif
              pre_d    = '0;
              armed_d  = 1'b0;
              busy_d   = 1'b1;
              state_d  = RUN;
            end else begin
              // Zero-length countdown: terminal count immediately.
              done_d = 1'b1;
            end
          end
        end

        RUN: begin
          busy_d = 1'b1;
          if (!pause) begin
            if (!armed_q) begin
              armed_d = 1'b1;
            end else if (pre_q == PRE_MAX) begin
              pre_d = '0;
              if (count_q <= WIDTH'(1)) begin
                done_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = DONE;
`endif
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end else begin
              pre_d = pre_q + PW'(1);
            end
          end
        end

        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          count_d = '0;
        end

        default: begin
          state_d = IDLE;
          count_d = '0;
          pre_d   = '0;
          armed_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      pre_q    <= '0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      armed_q  <= armed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [2:0] load_val;
  logic [2:0] count1, count2;
  logic       busy1, busy2, done1, done2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  down_counter_ctrl #(.WIDTH(3), .DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .count(count1), .busy(busy1), .done(done1)
  );

  down_counter_ctrl #(.WIDTH(3), .DIV(2)) u_div2 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .count(count2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic [2:0] lv;
    logic       pa;
    logic       ab;
    logic [2:0] c;
    logic       b;
    logic       d;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic r, input logic s, input logic [2:0] lv,
                   input logic p, input logic a,
                   input logic [2:0] c, input logic b, input logic d);
    vec_t e;
    e.rst = r; e.st = s; e.lv = lv; e.pa = p; e.ab = a;
    e.c = c; e.b = b; e.d = d;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive inputs away from the edge, let one rising edge pass, then
  // sample 1 time unit after it.
  task automatic step(input logic r, input logic s, input logic [2:0] lv,
                      input logic p, input logic a);
    reset = r; start = s; load_val = lv; pause = p; abort = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] e2c[9];
    logic       e2b[9];
    logic       e2d[9];

    reset = 1'b1; start = 1'b0; load_val = '0; pause = 1'b0; abort = 1'b0;
    @(negedge clk);

`ifndef AUTO_RELOAD_EN
    //   rst st lv  pa ab   count busy done
    v(1, 0, 0, 0, 0,  0, 0, 0);   // reset state
    v(1, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 5, 0, 0,  5, 1, 0);   // E0: load 5
    v(0, 0, 0, 0, 0,  5, 1, 0);   // arming cycle
    v(0, 0, 0, 0, 0,  4, 1, 0);
    v(0, 1, 7, 0, 0,  3, 1, 0);   // start while busy ignored
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 0, 0, 0, 0,  1, 1, 0);
    v(0, 0, 0, 0, 0,  0, 1, 1);   // done 6 edges after E0
    v(0, 1, 6, 0, 0,  0, 0, 0);   // start in DONE ignored, busy falls
    v(0, 1, 2, 0, 0,  2, 1, 0);   // back-to-back start accepted
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 0, 0, 0, 0,  1, 1, 0);
    v(0, 0, 0, 0, 0,  0, 1, 1);
    v(0, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 6, 0, 0,  6, 1, 0);   // E0: load 6
    v(0, 0, 0, 0, 0,  6, 1, 0);
    v(0, 0, 0, 0, 0,  5, 1, 0);
    v(0, 0, 0, 0, 0,  4, 1, 0);
    v(0, 0, 0, 1, 0,  4, 1, 0);   // pause x3 holds 4
    v(0, 0, 0, 1, 0,  4, 1, 0);
    v(0, 0, 0, 1, 0,  4, 1, 0);
    v(0, 0, 0, 0, 0,  3, 1, 0);
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 0, 0, 0, 0,  1, 1, 0);
    v(0, 0, 0, 0, 0,  0, 1, 1);   // E0+10: 3 cycles later than unpaused
    v(0, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 4, 0, 0,  4, 1, 0);
    v(0, 0, 0, 0, 0,  4, 1, 0);
    v(0, 0, 0, 0, 0,  3, 1, 0);
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 0, 0, 0, 1,  0, 0, 0);   // abort at count 2
    v(0, 0, 0, 0, 0,  0, 0, 0);   // no done after abort
    v(0, 1, 5, 0, 1,  0, 0, 0);   // start+abort: abort wins
    v(0, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 0, 0, 0,  0, 0, 1);   // load_val 0: done only
    v(0, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 5, 0, 0,  5, 1, 0);
    v(0, 0, 0, 0, 0,  5, 1, 0);
    v(1, 0, 0, 0, 0,  0, 0, 0);   // reset mid-run, held 2 cycles
    v(1, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 3, 0, 0,  3, 1, 0);   // next start after reset
    v(0, 0, 0, 0, 0,  3, 1, 0);
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 0, 0, 0, 0,  1, 1, 0);
    v(0, 0, 0, 0, 0,  0, 1, 1);
    v(0, 0, 0, 0, 0,  0, 0, 0);
`else
    //   rst st lv  pa ab   count busy done
    v(1, 0, 0, 0, 0,  0, 0, 0);
    v(1, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 3, 0, 0,  3, 1, 0);   // E0: load 3, periodic
    v(0, 0, 0, 0, 0,  3, 1, 0);
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 1, 6, 0, 0,  1, 1, 0);   // start while running ignored
    v(0, 0, 0, 0, 0,  3, 1, 1);   // 1 -> 3 with done
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 0, 0, 0, 0,  1, 1, 0);
    v(0, 0, 0, 0, 0,  3, 1, 1);
    v(0, 0, 0, 0, 0,  2, 1, 0);
    v(0, 0, 0, 0, 0,  1, 1, 0);
    v(0, 0, 0, 0, 0,  3, 1, 1);
    v(0, 0, 0, 0, 1,  0, 0, 0);   // abort stops the loop
    v(0, 0, 0, 0, 0,  0, 0, 0);
    v(0, 1, 0, 0, 0,  0, 0, 1);   // load_val 0: done only
    v(0, 0, 0, 0, 0,  0, 0, 0);
`endif

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].lv, tbl[i].pa, tbl[i].ab);
      chk("div1_count", i, 32'(count1), 32'(tbl[i].c));
      chk("div1_busy",  i, 32'(busy1),  32'(tbl[i].b));
      chk("div1_done",  i, 32'(done1),  32'(tbl[i].d));
    end

`ifndef AUTO_RELOAD_EN
    // DIV=2, load 3: each value held 2 cycles, done after edge E0+7,
    // a start during RUN changes nothing.
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("div2_reset_count", 0, 32'(count2), 32'd0);
    chk("div2_reset_busy",  0, 32'(busy2),  32'd0);
    e2c = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
    e2b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e2d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 9; k++) begin
      if (k == 0)      step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
      else if (k == 2) step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
      else             step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      chk("div2_count", k, 32'(count2), 32'(e2c[k]));
      chk("div2_busy",  k, 32'(busy2),  32'(e2b[k]));
      chk("div2_done",  k, 32'(done2),  32'(e2d[k]));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_ctrl.md
# down_counter_ctrl

Sequencing controller for the 3-bit down counter datapath: loads a start value, decrements it at a programmable rate, supports pause and abort, and signals terminal count. Replaces free-running down counters wherever software or upstream logic needs a one-shot (or, optionally, periodic) countdown with a clean done indication. Fully synchronous, single clock domain.

## Interface
- WIDTH, 3, counter width in bits (≥1)
- DIV, 1, clock cycles per decrement (≥1); prescaler width = clog2(DIV), minimum 1
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  input  1  begin countdown (sampled in IDLE only)
- load_val  input  WIDTH  start value, captured on accepted start
- pause  input  1  level; freezes prescaler and count while high in RUN
- abort  input  1  cancel; returns to IDLE, no done
- count  output  WIDTH  current count value (registered)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse at terminal count (registered)

## Operation
- States: IDLE, RUN, DONE. Priority per edge: reset > abort > start/count logic.
- Reset: state=IDLE, count=0, busy=0, done=0, prescaler=0, reload register=0.
- IDLE, start=1, load_val≠0: count←load_val, reload←load_val, prescaler←0, state←RUN.
- IDLE, start=1, load_val=0: state stays IDLE, done pulses one cycle, busy stays 0.
- RUN, pause=0: prescaler increments; at DIV-1 it wraps to 0 and count decrements. DIV=1: decrement every cycle.
- RUN, pause=1: prescaler and count hold; busy=1; done cannot assert.
- RUN, decrement from 1: count←0, done←1, state←DONE.
- DONE: one cycle; done=1, busy=1; next edge state←IDLE, done←0, busy←0; count holds 0.
- start while busy: ignored. load_val changes while busy: ignored.
- abort (any state): next edge state←IDLE, count←0, prescaler←0, done←0. abort with start in IDLE: abort wins, nothing loaded.
- count never underflows; no arithmetic wrap below 0.

## Timing
- Start sampled at edge E0. count=load_val (N) from E0+1.
- Count decrements at edges E0+1+k·DIV, k=1..N.
- done high for exactly one cycle after edge E0+1+N·DIV; busy falls at edge E0+2+N·DIV.
- Each pause-high cycle in RUN delays done by exactly one cycle.
- Back-to-back: a start sampled in the first IDLE cycle after DONE is accepted (one idle cycle minimum between runs).
- Reset asserted mid-run takes effect at that edge; outputs are reset values the following cycle.

## Configuration
- Macro AUTO_RELOAD_EN.
- Defined: in RUN, decrement from 1 loads count←reload instead of 0, done pulses that cycle, state stays RUN (periodic mode, period N·DIV cycles). Exit only via abort or reset. DONE is never entered. load_val=0 behaves as in the default build.
- Not defined: one-shot behaviour as described above; reload register may be optimised away.

## Test plan
- Reset held 2 cycles during RUN with count=5 -> count=0, busy=0, done=0, next start accepted normally.
- WIDTH=3, DIV=1, start with load_val=5 -> count 5,4,3,2,1,0 on consecutive cycles; done single pulse with count=0, 6 cycles after start edge; busy low 1 cycle later.
- DIV=2, load_val=3 -> each value held 2 cycles; done after edge E0+7; start asserted during RUN has no effect.
- load_val=6, pause high for 3 cycles when count=4 -> count holds 4 for those cycles; done delayed by exactly 3 cycles versus unpaused run.
- abort at count=2 -> IDLE, count=0, no done pulse; start+abort same cycle in IDLE -> stays IDLE; start with load_val=0 -> one done pulse, busy stays 0.
- AUTO_RELOAD_EN, DIV=1, load_val=3 -> count 3,2,1,3,2,1…; done pulses on each 1→3 transition (every 3 cycles), busy constantly 1; abort -> count=0, IDLE.
